bist_control_multi: RTL
=======================

// Module: bist_control_multi
// PURPOSE
//  Parametrised next-generation BIST sequencer. Runs M rounds of N shift cycles plus one capture cycle,
//  switches LFSR seed after a programmable round, and supports optional repeat sessions and ABORT.
//  Compares the MISR signature against a golden value and reports PASS/FAIL.
//  Sits between the top-level test port (START) and the LFSR/MISR/scan-enable datapath.
// PARAMETERS
//  N_SHIFT     9       shift cycles per round (>=1)
//  M_ROUNDS    40      rounds per session (>=1)
//  SEED_ROUND  4       first round index (0-based) driving SEED=1; >=M_ROUNDS means never
//  SESSIONS    1       back-to-back sessions per START (>=1); INIT re-pulsed between sessions
//  SIG_W       16      MISR signature width
//  GOLDEN      16'h0   expected signature, compared at each session end
// PORTS
//  CLK        in   1      rising-edge clock
//  RESET_N    in   1      synchronous reset, active-low
//  START      in   1      level request; a 0->1 edge (after being seen low) starts a run
//  ABORT      in   1      synchronous abort, effective in INIT/RUN/CHECK
//  SIG_IN     in   SIG_W  MISR signature, sampled in CHECK
//  INIT       out  1      one-cycle pulse: reset/load LFSR and MISR
//  RUNNING    out  1      high in RUN (shift and capture cycles)
//  OUT        out  1      scan-enable: high on shift cycles, low on capture cycle
//  SEED       out  1      seed-select, high on shift cycles of rounds >= SEED_ROUND
//  FINISH     out  1      one-cycle pulse when the last session completes
//  BIST_END   out  1      high from final CHECK until next INIT or ABORT
//  PASS       out  1      all sessions matched GOLDEN; valid while BIST_END=1
//  FAIL       out  1      any session mismatched; sticky until next run's INIT
//  ROUND      out  $clog2(M_ROUNDS+1)  current round index, 0 outside RUN
// BEHAVIOUR
//  Reset (RESET_N=0 at CLK edge): state=IDLE; counters, session count, PASS, FAIL and all outputs 0.
//  Reset overrides ABORT and START on the same edge. Reset mid-run returns to IDLE with no FINISH.
//  All outputs are decoded from registered state/counters (no START/ABORT combinational paths).
//  States:
//   IDLE   : START=0 -> ARMED. Guarantees START is seen low after reset.
//   ARMED  : START=1 -> INIT.
//   INIT   : INIT=1 for exactly 1 cycle; clear cnt_n, cnt_m; -> RUN. First INIT of a run clears PASS/FAIL/BIST_END.
//   RUN    : cnt_n 0..N_SHIFT-1 shift (OUT=1); cnt_n==N_SHIFT capture (OUT=0, RUNNING=1).
//            After capture: cnt_n<=0, cnt_m++. Capture of round M_ROUNDS-1 -> CHECK.
//            Session length = M_ROUNDS*(N_SHIFT+1) cycles.
//   CHECK  : 1 cycle; RUNNING=0. Sample SIG_IN != GOLDEN -> FAIL<=1 (sticky).
//            If sessions_done+1 < SESSIONS: sessions_done++, -> INIT.
//            Else -> DONE_HI with FINISH=1, BIST_END=1, PASS<=~FAIL_next.
//   DONE_HI: BIST_END=1; START=0 -> DONE_LO.
//   DONE_LO: BIST_END=1; START=1 -> INIT (new run, sessions_done<=0).
//  START: ignored outside IDLE/ARMED/DONE_HI/DONE_LO. Holding START high does not retrigger a run.
//  ABORT in INIT/RUN/CHECK: -> IDLE next edge; FAIL<=1, PASS<=0, BIST_END<=0, no FINISH. Ignored elsewhere.
//  Counter widths: cnt_n $clog2(N_SHIFT+1), cnt_m $clog2(M_ROUNDS+1). No wrap-around inside a session.
//  Illegal state encodings -> IDLE with all outputs 0.
// STRUCTURE
//  Package bist_pkg: state encoding localparams (IDLE..DONE_LO) and a clog2-based width helper.
//  Package contents are shared with LFSR/MISR blocks.
//  Sub-module bist_round_counter: nested cnt_n/cnt_m counter with clear/enable inputs;
//  outputs last_shift, capture and last_round flags. The FSM stays in the top module.
// TESTING
//  Defaults, START 0->1: INIT pulse 1 cycle, then RUNNING=1 for 400 cycles and OUT=1 for 360;
//   SEED=1 from round 4; FINISH 1 cycle; BIST_END=1.
//  SIG_IN==GOLDEN at CHECK -> PASS=1, FAIL=0. SIG_IN=16'h0001 -> PASS=0, FAIL=1; both held until next INIT.
//  START held 1 through reset and across DONE_HI -> no run starts until START falls and rises again.
//  SESSIONS=3, mismatch only in session 2 -> 3 INIT pulses, 1 FINISH, FAIL=1.
//  ABORT at round 10 -> IDLE next cycle; RUNNING=0; FAIL=1; no FINISH.
//   RESET_N=0 at round 10 -> all outputs 0 next cycle.
//  N_SHIFT=1, M_ROUNDS=1 -> RUN lasts 2 cycles (OUT=1 then 0). SEED_ROUND=40 -> SEED never asserted.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared definitions for the BIST sequencer, LFSR and MISR blocks:
// the FSM state encoding and a counter-width helper.
package bist_pkg;

  localparam int BIST_STATE_W = 3;

  typedef enum logic [BIST_STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_INIT    = 3'd2,
    ST_RUN     = 3'd3,
    ST_CHECK   = 3'd4,
    ST_DONE_HI = 3'd5,
    ST_DONE_LO = 3'd6
  } bist_state_e;

  // Bits needed to hold the values 0..n; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bist_round_counter.sv
// Nested shift/round counter: cnt_n walks 0..N_SHIFT (N_SHIFT is the capture
// cycle), then cnt_m advances. Clear has priority over enable.
module bist_round_counter
  import bist_pkg::*;
#(
  parameter int N_SHIFT  = 9,
  parameter int M_ROUNDS = 40
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic                            clear_i,
  input  logic                            en_i,
  output logic [cnt_width(N_SHIFT)-1:0]   cnt_n_o,
  output logic [cnt_width(M_ROUNDS)-1:0]  cnt_m_o,
  output logic                            last_shift_o,
  output logic                            capture_o,
  output logic                            last_round_o
);

  localparam int NW = cnt_width(N_SHIFT);
  localparam int MW = cnt_width(M_ROUNDS);

  logic [NW-1:0] cnt_n_q, cnt_n_d;
  logic [MW-1:0] cnt_m_q, cnt_m_d;

  assign last_shift_o = (cnt_n_q == NW'(N_SHIFT - 1));
  assign capture_o    = (cnt_n_q == NW'(N_SHIFT));
  assign last_round_o = (cnt_m_q == MW'(M_ROUNDS - 1));
  assign cnt_n_o      = cnt_n_q;
  assign cnt_m_o      = cnt_m_q;

  always_comb begin
    cnt_n_d = cnt_n_q;
    cnt_m_d = cnt_m_q;
    if (clear_i) begin
      cnt_n_d = '0;
      cnt_m_d = '0;
    end else if (en_i) begin
      // cnt_m reaches M_ROUNDS after the last capture; the width holds it
      if (capture_o) begin
        cnt_n_d = '0;
        cnt_m_d = cnt_m_q + MW'(1);
      end else begin
        cnt_n_d = cnt_n_q + NW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_n_q <= '0;
      cnt_m_q <= '0;
    end else begin
      cnt_n_q <= cnt_n_d;
      cnt_m_q <= cnt_m_d;
    end
  end

endmodule

// File: rtl/bist_control_multi.sv
// BIST sequencer: M rounds of N shift cycles plus a capture cycle per session,
// optional repeat sessions, abort, and golden-signature PASS/FAIL reporting.
//
// state   | meaning
// IDLE    | after reset/abort; waits for START low
// ARMED   | START seen low; waits for START high
// INIT    | one-cycle LFSR/MISR load pulse, counters cleared
// RUN     | shift cycles (OUT=1) and capture cycle (OUT=0)
// CHECK   | sample signature, next session or finish
// DONE_HI | results valid; waits for START low
// DONE_LO | results valid; START high begins a new run
module bist_control_multi
  import bist_pkg::*;
#(
  parameter int               N_SHIFT    = 9,
  parameter int               M_ROUNDS   = 40,
  parameter int               SEED_ROUND = 4,
  parameter int               SESSIONS   = 1,
  parameter int               SIG_W      = 16,
  parameter logic [SIG_W-1:0] GOLDEN     = '0
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic                            start_i,
  input  logic                            abort_i,
  input  logic [SIG_W-1:0]                sig_in_i,
  output logic                            init_o,
  output logic                            running_o,
  output logic                            out_o,
  output logic                            seed_o,
  output logic                            finish_o,
  output logic                            bist_end_o,
  output logic                            pass_o,
  output logic                            fail_o,
  output logic [cnt_width(M_ROUNDS)-1:0]  round_o
);

  localparam int NW     = cnt_width(N_SHIFT);
  localparam int MW     = cnt_width(M_ROUNDS);
  localparam int SESS_W = cnt_width(SESSIONS);

  localparam bit              SEED_EN    = (SEED_ROUND < M_ROUNDS);
  localparam logic [MW-1:0]   SEED_START = SEED_EN ? MW'(SEED_ROUND) : '0;
  localparam logic [SESS_W-1:0] LAST_SESS = SESS_W'(SESSIONS - 1);

  bist_state_e       state_q, state_d;
  logic [SESS_W-1:0] sess_q, sess_d;
  logic              pass_q, pass_d;
  logic              fail_q, fail_d;
  logic              finish_q, finish_d;
  logic              fail_nx;

  logic              cnt_clear, cnt_en;
  logic [NW-1:0]     cnt_n;
  logic [MW-1:0]     cnt_m;
  logic              capture, last_round;
  logic              unused_last_shift;

  bist_round_counter #(
    .N_SHIFT  (N_SHIFT),
    .M_ROUNDS (M_ROUNDS)
  ) u_cnt (
    .clk_i        (clk_i),
    .rst_n_i      (reset_n_i),
    .clear_i      (cnt_clear),
    .en_i         (cnt_en),
    .cnt_n_o      (cnt_n),
    .cnt_m_o      (cnt_m),
    .last_shift_o (unused_last_shift),
    .capture_o    (capture),
    .last_round_o (last_round)
  );

  always_comb begin
    state_d   = state_q;
    sess_d    = sess_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    finish_d  = 1'b0;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    fail_nx   = fail_q | (sig_in_i != GOLDEN);

    case (state_q)
      ST_IDLE: begin
        if (!start_i) state_d = ST_ARMED;
      end
      ST_ARMED, ST_DONE_LO: begin
        // a fresh run clears the previous run's verdict
        if (start_i) begin
          state_d = ST_INIT;
          sess_d  = '0;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
        end
      end
      ST_INIT: begin
        cnt_clear = 1'b1;
        state_d   = ST_RUN;
      end
      ST_RUN: begin
        cnt_en = 1'b1;
        if (capture && last_round) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        fail_d = fail_nx;
        if (sess_q < LAST_SESS) begin
          sess_d  = sess_q + SESS_W'(1);
          state_d = ST_INIT;
        end else begin
          state_d  = ST_DONE_HI;
          finish_d = 1'b1;
          pass_d   = ~fail_nx;
        end
      end
      ST_DONE_HI: begin
        if (!start_i) state_d = ST_DONE_LO;
      end
      default: begin
        state_d = ST_IDLE;
        sess_d  = '0;
        pass_d  = 1'b0;
        fail_d  = 1'b0;
      end
    endcase

    if (abort_i && (state_q == ST_INIT || state_q == ST_RUN || state_q == ST_CHECK)) begin
      state_d   = ST_IDLE;
      pass_d    = 1'b0;
      fail_d    = 1'b1;
      finish_d  = 1'b0;
      cnt_clear = 1'b0;
      cnt_en    = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q  <= ST_IDLE;
      sess_q   <= '0;
      pass_q   <= 1'b0;
      fail_q   <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sess_q   <= sess_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      finish_q <= finish_d;
    end
  end

  assign init_o     = (state_q == ST_INIT);
  assign running_o  = (state_q == ST_RUN);
  assign out_o      = running_o && !capture;
  assign seed_o     = out_o && SEED_EN && (cnt_m >= SEED_START);
  assign finish_o   = finish_q;
  assign bist_end_o = (state_q == ST_DONE_HI) || (state_q == ST_DONE_LO);
  assign pass_o     = pass_q;
  assign fail_o     = fail_q;
  assign round_o    = running_o ? cnt_m : '0;

endmodule
